// File: rtl/matmul_pkg.sv
// matmul_pkg: state encoding and sizing helper shared by the matmul stream core
package matmul_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_A  = 3'd1;
    localparam logic [2:0] ST_LOAD_B  = 3'd2;
    localparam logic [2:0] ST_COMPUTE = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        LOAD_A  = ST_LOAD_A,
        LOAD_B  = ST_LOAD_B,
        COMPUTE = ST_COMPUTE,
        SEND    = ST_SEND
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/mat_bank.sv
// mat_bank: square matrix register file, one write port and one combinational read port
module mat_bank
    import matmul_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]           wdata,
    input  logic [clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]           rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    assign rdata = mem_q[raddr];

    // write one element; contents are never reset and persist between jobs
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // storage register
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/matmul_stream_core.sv
// matmul_stream_core: byte-streamed square matrix multiply, one MAC per cycle
module matmul_stream_core
    import matmul_pkg::*;
#(
    parameter int DW    = 8,
    parameter int MAX_N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state
);

    localparam int RW = 2 * DW + clog2(MAX_N);
    localparam int RB = (RW + 7) / 8;
    localparam int NW = clog2(MAX_N + 1);
    localparam int AW = clog2(MAX_N * MAX_N);
    localparam int BW = clog2(RB);
    localparam logic [7:0] MAXN_B = 8'(MAX_N);
    localparam logic [BW-1:0] LAST_BYTE = BW'(RB - 1);

    state_t          state_q, state_d;
    logic [NW-1:0]   n_q, n_d, i_q, i_d, j_q, j_d, k_q, k_d, last;
    logic [BW-1:0]   byte_q, byte_d;
    logic [RW-1:0]   acc_q, acc_d, prod;
    logic            err_q, err_d, we_a, we_b;
    logic [AW-1:0]   waddr, raddr_a, raddr_b;
    logic [DW-1:0]   a_rd, b_rd;
    logic [RB*8-1:0] acc_ext;

    assign last      = n_q - NW'(1);
    assign waddr     = AW'(32'(i_q) * MAX_N + 32'(j_q));
    assign raddr_a   = AW'(32'(i_q) * MAX_N + 32'(k_q));
    assign raddr_b   = AW'(32'(k_q) * MAX_N + 32'(j_q));
    assign prod      = RW'(a_rd) * RW'(b_rd);
    assign acc_ext   = (RB * 8)'(acc_q);
    assign out_data  = 8'(acc_ext >> {byte_q, 3'b000});
    assign in_ready  = (state_q == IDLE) || (state_q == LOAD_A) || (state_q == LOAD_B);
    assign out_valid = state_q == SEND;
    assign busy      = state_q != IDLE;
    assign state     = state_q;
    assign err       = err_q;

    mat_bank #(.DW(DW), .DEPTH(MAX_N * MAX_N)) u_bank_a (
        .clk(clk), .we(we_a), .waddr(waddr), .wdata(DW'(in_data)), .raddr(raddr_a), .rdata(a_rd)
    );

    mat_bank #(.DW(DW), .DEPTH(MAX_N * MAX_N)) u_bank_b (
        .clk(clk), .we(we_b), .waddr(waddr), .wdata(DW'(in_data)), .raddr(raddr_b), .rdata(b_rd)
    );

    // job sequencing: size byte, row-major loads, per-element MAC loop, little-endian result bytes
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        byte_d  = byte_q;
        acc_d   = acc_q;
        err_d   = 1'b0;
        we_a    = 1'b0;
        we_b    = 1'b0;
        done    = 1'b0;
        if (abort) begin
            state_d = IDLE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            byte_d  = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    if (in_data != 8'd0 && in_data <= MAXN_B) begin
                        n_d     = NW'(in_data);
                        i_d     = '0;
                        j_d     = '0;
                        state_d = LOAD_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                LOAD_A, LOAD_B: if (in_valid) begin
                    we_a = state_q == LOAD_A;
                    we_b = state_q == LOAD_B;
                    j_d  = (j_q == last) ? '0 : j_q + 1'b1;
                    if (j_q == last) begin
                        i_d = (i_q == last) ? '0 : i_q + 1'b1;
                        if (i_q == last) begin
                            state_d = (state_q == LOAD_A) ? LOAD_B : COMPUTE;
                            k_d     = '0;
                            acc_d   = '0;
                        end
                    end
                end
                COMPUTE: begin
                    acc_d = acc_q + prod;
                    k_d   = (k_q == last) ? '0 : k_q + 1'b1;
                    if (k_q == last) begin
                        state_d = SEND;
                        byte_d  = '0;
                    end
                end
                SEND: if (out_ready) begin
                    byte_d = (byte_q == LAST_BYTE) ? '0 : byte_q + 1'b1;
                    if (byte_q == LAST_BYTE) begin
                        acc_d   = '0;
                        state_d = COMPUTE;
                        j_d     = (j_q == last) ? '0 : j_q + 1'b1;
                        if (j_q == last) begin
                            i_d = (i_q == last) ? '0 : i_q + 1'b1;
                            if (i_q == last) begin
                                state_d = IDLE;
                                done    = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state registers with reset taking priority over every input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            byte_q  <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            byte_q  <= byte_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_matmul_stream_core.sv
// tb_matmul_stream_core: directed self-checking bench for the matmul stream core
module tb_matmul_stream_core;

    logic       clk = 1'b0;
    logic       rst, in_valid, abort, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, busy, done, err;
    logic [7:0] out_data;
    logic [2:0] state;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] got [64];
    int         got_n, done_cnt, mac_cyc;

    always #5 clk = ~clk;

    matmul_stream_core #(.DW(8), .MAX_N(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .abort(abort), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err), .state(state)
    );

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input int nbytes);
        int t;
        t        = 0;
        got_n    = 0;
        done_cnt = 0;
        mac_cyc  = 0;
        while (got_n < nbytes && t < 4000) begin
            @(negedge clk);
            t++;
            if (state == 3'd3) mac_cyc++;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                got[got_n] = out_data;
                got_n++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; abort = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({state, in_ready, out_valid, out_data, busy, done, err} !== {3'd0, 1'b1, 1'b0, 8'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want %h", {state, in_ready, out_valid, out_data, busy, done, err},
                     {3'd0, 1'b1, 1'b0, 8'd0, 3'b000});
        end
    endtask

    task automatic test_n2();
        int e [12] = '{19, 0, 0, 22, 0, 0, 43, 0, 0, 50, 0, 0};
        send_byte(8'd2);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        collect(12);
        vectors++;
        if (got_n !== 12) begin miscompares++; $display("FAIL n2_count got %0d want 12", got_n); end
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (got[i] !== 8'(e[i])) begin miscompares++; $display("FAIL n2_byte%0d got %0d want %0d", i, got[i], e[i]); end
        end
        vectors++;
        if (done_cnt !== 1) begin miscompares++; $display("FAIL n2_done got %0d want 1", done_cnt); end
        vectors++;
        if (mac_cyc !== 8) begin miscompares++; $display("FAIL n2_mac_cycles got %0d want 8", mac_cyc); end
        vectors++;
        if ({state, busy} !== 4'b0000) begin miscompares++; $display("FAIL n2_idle_after got %b want 0000", {state, busy}); end
    endtask

    task automatic test_n4_max();
        logic [7:0] e [3] = '{8'h04, 8'hF8, 8'h03};
        send_byte(8'd4);
        for (int i = 0; i < 32; i++) send_byte(8'd255);
        collect(48);
        vectors++;
        if (got_n !== 48) begin miscompares++; $display("FAIL n4_count got %0d want 48", got_n); end
        for (int i = 0; i < 48; i++) begin
            vectors++;
            if (got[i] !== e[i % 3]) begin miscompares++; $display("FAIL n4_byte%0d got %h want %h", i, got[i], e[i % 3]); end
        end
        vectors++;
        if (done_cnt !== 1) begin miscompares++; $display("FAIL n4_done got %0d want 1", done_cnt); end
        vectors++;
        if (mac_cyc !== 64) begin miscompares++; $display("FAIL n4_mac_cycles got %0d want 64", mac_cyc); end
    endtask

    task automatic test_err_sizes();
        logic [7:0] bad [2] = '{8'd0, 8'd9};
        for (int b = 0; b < 2; b++) begin
            send_byte(bad[b]);
            @(negedge clk);
            vectors++;
            if ({err, state, in_ready} !== {1'b1, 3'd0, 1'b1}) begin
                miscompares++;
                $display("FAIL err_size%0d got err/state/rdy %b want 1_000_1", bad[b], {err, state, in_ready});
            end
            @(negedge clk);
            vectors++;
            if (err !== 1'b0) begin miscompares++; $display("FAIL err_pulse_width%0d got %b want 0", bad[b], err); end
        end
        send_byte(8'd1);
        send_byte(8'd7);
        send_byte(8'd6);
        collect(3);
        vectors++;
        if ({got_n[7:0], got[0], got[1], got[2]} !== {8'd3, 8'd42, 8'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL n1_result got n=%0d %0d,%0d,%0d want 3 42,0,0", got_n, got[0], got[1], got[2]);
        end
        vectors++;
        if (done_cnt !== 1) begin miscompares++; $display("FAIL n1_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        int e [12] = '{19, 0, 0, 22, 0, 0, 43, 0, 0, 50, 0, 0};
        int t;
        out_ready = 1'b0;
        send_byte(8'd2);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        t = 0;
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_wait_valid got %b want 1", out_valid); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, out_data} !== {1'b1, 8'd19}) begin
                miscompares++;
                $display("FAIL bp_hold%0d got valid=%b data=%0d want 1 19", c, out_valid, out_data);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        collect(12);
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (got[i] !== 8'(e[i])) begin miscompares++; $display("FAIL bp_byte%0d got %0d want %0d", i, got[i], e[i]); end
        end
        vectors++;
        if (done_cnt !== 1) begin miscompares++; $display("FAIL bp_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_abort();
        int e [12] = '{8, 0, 0, 10, 0, 0, 22, 0, 0, 26, 0, 0};
        int a [8] = '{2, 0, 1, 3, 4, 5, 6, 7};
        send_byte(8'd2);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        abort = 1'b1;
        @(negedge clk);
        vectors++;
        if ({done, err} !== 2'b00) begin miscompares++; $display("FAIL abort_no_pulse got done/err %b want 00", {done, err}); end
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        vectors++;
        if ({state, busy, in_ready, done, err} !== {3'd0, 1'b0, 1'b1, 2'b00}) begin
            miscompares++;
            $display("FAIL abort_idle got %b want 000_0_1_00", {state, busy, in_ready, done, err});
        end
        send_byte(8'd2);
        for (int i = 0; i < 8; i++) send_byte(8'(a[i]));
        collect(12);
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (got[i] !== 8'(e[i])) begin miscompares++; $display("FAIL abort_job_byte%0d got %0d want %0d", i, got[i], e[i]); end
        end
        vectors++;
        if (done_cnt !== 1) begin miscompares++; $display("FAIL abort_job_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_rst_mid_send();
        int e [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        int b [9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        int t;
        out_ready = 1'b0;
        send_byte(8'd1);
        send_byte(8'd200);
        send_byte(8'd100);
        t = 0;
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        vectors++;
        if ({out_valid, out_data} !== {1'b1, 8'h20}) begin
            miscompares++;
            $display("FAIL rst_pre_send got valid=%b data=%h want 1 20", out_valid, out_data);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({state, in_ready, out_valid, out_data, busy, done, err} !== {3'd0, 1'b1, 1'b0, 8'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL rst_mid_send got %h want %h", {state, in_ready, out_valid, out_data, busy, done, err},
                     {3'd0, 1'b1, 1'b0, 8'd0, 3'b000});
        end
        send_byte(8'd3);
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        for (int i = 0; i < 9; i++) send_byte(8'(b[i]));
        collect(27);
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if ({got[3*i], got[3*i+1], got[3*i+2]} !== {8'(e[i]), 16'd0}) begin
                miscompares++;
                $display("FAIL n3_elem%0d got %0d,%0d,%0d want %0d,0,0", i, got[3*i], got[3*i+1], got[3*i+2], e[i]);
            end
        end
        vectors++;
        if ({done_cnt[7:0], mac_cyc[7:0]} !== {8'd1, 8'd27}) begin
            miscompares++;
            $display("FAIL n3_done_mac got done=%0d mac=%0d want 1 27", done_cnt, mac_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_n2();
        test_n4_max();
        test_err_sizes();
        test_backpressure();
        test_abort();
        test_rst_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
